// File: rtl/fsm_rd_pkg.sv
// Shared types and defaults for the wait-state read responder.
// Holds the FSM state encoding and the default data width and FIFO depth.
package fsm_rd_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int WAIT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_READY = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/rd_fifo.sv
// Power-of-two FIFO with separate push/pop strobes and a combinational head.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module rd_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push_s;
    logic              do_pop_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign head_o    = mem_q[rd_ptr_q];

    // Pointers and occupancy count; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1'b1);
                2'b01:   count_q <= count_q - CW'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fsm_rd_responder.sv
// Read responder: inserts a programmable number of wait states, then
// returns the FIFO head; the initiator's done strobe pops the entry.
module fsm_rd_responder
    import fsm_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              ds,
    output logic              ws,
    output logic [DATA_W-1:0] rdata,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [WAIT_W-1:0] wait_cfg,
    output logic              full,
    output logic              empty,
    output logic              err
);
    state_t            state_q, state_d;
    logic              ws_q, ws_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              pop_s;
    logic              proto_err_s;
    logic              ovf_s;
    logic [DATA_W-1:0] head_s;

    rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (wr_en),
        .wr_data_i (wr_data),
        .pop_i     (pop_s),
        .head_o    (head_s),
        .full_o    (full),
        .empty_o   (empty)
    );

    // Next-state, wait counter, registered ws/rdata and error decode.
    always_comb begin
        state_d     = state_q;
        ws_d        = ws_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        pop_s       = 1'b0;
        proto_err_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                proto_err_s = ds;
                if (rd) begin
                    cnt_d = wait_cfg;
                    if ((wait_cfg != {WAIT_W{1'b0}}) || empty) begin
                        state_d = ST_BUSY;
                        ws_d    = 1'b1;
                    end else begin
                        state_d = ST_READY;
                        ws_d    = 1'b0;
                        rdata_d = head_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                    ws_d    = 1'b0;
                end
            end
            ST_BUSY: begin
                proto_err_s = ds;
                if (!rd) begin
                    state_d = ST_IDLE;
                    ws_d    = 1'b0;
                end else begin
                    if (cnt_q != {WAIT_W{1'b0}}) begin
                        cnt_d = cnt_q - WAIT_W'(1'b1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                    // Leave on the cycle the count reaches zero, so ws lasts wait_cfg cycles.
                    if ((cnt_q <= WAIT_W'(1'b1)) && !empty) begin
                        state_d = ST_READY;
                        ws_d    = 1'b0;
                        rdata_d = head_s;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_READY, ST_HOLD: begin
                if (ds) begin
                    pop_s   = 1'b1;
                    state_d = ST_IDLE;
                end else if (rd) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
                ws_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                ws_d    = 1'b0;
            end
        endcase
        ovf_s = wr_en && full && !pop_s;
        err_d = err_q | proto_err_s | ovf_s;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ws_q    <= 1'b0;
            rdata_q <= {DATA_W{1'b0}};
            cnt_q   <= {WAIT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ws_q    <= ws_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign ws    = ws_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_fsm_rd_responder.sv
// Scoreboard bench for fsm_rd_responder: pushed words are queued as expected
// read data and compared when the responder presents them.
module tb_fsm_rd_responder;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd;
    logic       ds;
    logic       ws;
    logic [7:0] rdata;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [3:0] wait_cfg;
    logic       full;
    logic       empty;
    logic       err;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb[$];
    logic       m_err = 1'b0;

    always #5 clk = ~clk;

    fsm_rd_responder #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd),
        .ds       (ds),
        .ws       (ws),
        .rdata    (rdata),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wait_cfg (wait_cfg),
        .full     (full),
        .empty    (empty),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (sb.size() < DEPTH) sb.push_back(d);
        else m_err = 1'b1;
        chk("push_full", 32'(full), 32'(sb.size() == DEPTH));
        chk("push_empty", 32'(empty), 32'(sb.size() == 0));
        chk("push_err", 32'(err), 32'(m_err));
    endtask

    // Full read: wait states, one hold cycle, then ds (optionally with a push in the pop cycle).
    task automatic do_read(input logic [3:0] wcfg, input int exp_ws,
                           input logic push_en, input logic [7:0] pv);
        int         n;
        logic [7:0] e;
        n        = 0;
        rd       = 1'b1;
        wait_cfg = wcfg;
        tick();
        while (ws === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("ws_cycles", 32'(n), 32'(exp_ws));
        e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        chk("rdata", 32'(rdata), 32'(e));
        tick();
        chk("hold_ws", 32'(ws), 32'd0);
        chk("hold_rdata", 32'(rdata), 32'(e));
        ds = 1'b1;
        if (push_en) begin
            wr_en   = 1'b1;
            wr_data = pv;
        end
        tick();
        ds    = 1'b0;
        rd    = 1'b0;
        wr_en = 1'b0;
        if (push_en) sb.push_back(pv);
        chk("post_ws", 32'(ws), 32'd0);
        chk("post_empty", 32'(empty), 32'(sb.size() == 0));
        chk("post_full", 32'(full), 32'(sb.size() == DEPTH));
        chk("post_err", 32'(err), 32'(m_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst      = 1'b1;
        rd       = 1'b0;
        ds       = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        wait_cfg = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ws", 32'(ws), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        rst = 1'b0;
        tick();

        // Zero-wait read and a three-wait read.
        push(8'hA5);
        do_read(4'd0, 0, 1'b0, 8'h00);
        push(8'h3C);
        do_read(4'd3, 3, 1'b0, 8'h00);

        // Empty FIFO keeps ws high until data arrives.
        rd       = 1'b1;
        wait_cfg = 4'd0;
        tick();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (ws === 1'b1) n++;
            tick();
        end
        chk("empty_ws_cycles", 32'(n), 32'd10);
        push(8'h77);
        chk("ws_after_push", 32'(ws), 32'd1);
        tick();
        chk("ws_fall", 32'(ws), 32'd0);
        chk("late_rdata", 32'(rdata), 32'(sb.pop_front()));
        ds = 1'b1;
        tick();
        ds = 1'b0;
        rd = 1'b0;
        chk("late_empty", 32'(empty), 32'd1);

        // Abort in BUSY keeps the head entry.
        push(8'h5A);
        rd       = 1'b1;
        wait_cfg = 4'd4;
        tick();
        tick();
        chk("abort_busy_ws", 32'(ws), 32'd1);
        rd = 1'b0;
        tick();
        chk("abort_ws", 32'(ws), 32'd0);
        chk("abort_empty", 32'(empty), 32'd0);
        do_read(4'd0, 0, 1'b0, 8'h00);

        // Fill, overflow, drain, then a second fill across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        push(8'hFF);
        for (int i = 0; i < DEPTH; i++) do_read(4'(i % 4), i % 4, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i));
        do_read(4'd1, 1, 1'b1, 8'h99);
        for (int i = 0; i < DEPTH; i++) do_read(4'd0, 0, 1'b0, 8'h00);

        // Reset mid-BUSY with entries queued.
        push(8'h01);
        push(8'h02);
        push(8'h03);
        rd       = 1'b1;
        wait_cfg = 4'd5;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_ws", 32'(ws), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_err", 32'(err), 32'd0);
        sb.delete();
        m_err = 1'b0;
        rd    = 1'b0;
        #2 rst = 1'b0;
        tick();
        chk("idle_err_pre", 32'(err), 32'd0);
        ds = 1'b1;
        tick();
        ds    = 1'b0;
        m_err = 1'b1;
        chk("idle_ds_err", 32'(err), 32'(m_err));
        chk("idle_ds_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fsm_rd_responder.md
FSM_RD_RESPONDER -- requirements
Module: fsm_rd_responder

Interface
REQ-001 Parameter DATA_W, default 8: width of each read data word.
REQ-002 Parameter DEPTH, default 16: number of FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port rd, input, 1: read strobe from the initiator; level, high for the whole read cycle including wait loops.
REQ-006 Port ds, input, 1: done strobe from the initiator; one-cycle pulse that ends a read.
REQ-007 Port ws, output, 1: wait-state request to the initiator; registered.
REQ-008 Port rdata, output, DATA_W: read data; registered; valid while state is READY.
REQ-009 Port wr_en, input, 1: producer push strobe.
REQ-010 Port wr_data, input, DATA_W: producer push data.
REQ-011 Port wait_cfg, input, 4: minimum wait cycles per read; sampled when a read starts.
REQ-012 Port full, output, 1: FIFO holds DEPTH entries.
REQ-013 Port empty, output, 1: FIFO holds zero entries.
REQ-014 Port err, output, 1: sticky protocol or overflow error.

Function
REQ-015 The FSM SHALL have four states: IDLE, BUSY, READY and HOLD.
REQ-016 IDLE with rd=1: load the wait counter from wait_cfg.
  - Go to BUSY with ws<=1 if wait_cfg!=0 or the FIFO is empty.
  - Otherwise go to READY with ws<=0 and rdata<=head entry.
REQ-017 BUSY, each cycle with rd=1: decrement the counter while it is nonzero.
  - Leave BUSY when the counter reaches or is 0 and the FIFO is not empty.
  - On leaving: go to READY, ws<=0, rdata<=head entry.
REQ-018 READY with ds=1: pop the head entry and go to IDLE; rd may be 0 or 1 in that cycle.
REQ-019 READY with rd=1 and ds=0: go to HOLD; ws stays 0 and rdata is held.
REQ-020 HOLD with ds=1: pop the head entry and go to IDLE.
REQ-021 BUSY, READY or HOLD with rd=0 and ds=0 (abort): go to IDLE.
  - ws<=0; no pop; rdata unchanged.
REQ-022 ds=1 in IDLE or BUSY: no pop; set err.
REQ-023 Latency: with wait_cfg=0 and the FIFO non-empty, ws stays 0 for the whole read.
  - rdata is valid on the cycle after rd first rises.
REQ-024 Latency: with wait_cfg=N>0, ws is high for N cycles starting the cycle after rd rises.
REQ-025 An empty FIFO extends BUSY indefinitely; ws stays 1 until data is present.
REQ-026 wr_en when not full: push wr_data; the entry is visible to BUSY on the next cycle.
REQ-027 wr_en when full and no pop that cycle: drop the data and set err.
  - If a pop occurs in the same cycle, the push SHALL succeed.
REQ-028 Simultaneous push and pop on an empty FIFO cannot occur, because a pop requires READY, which requires non-empty.
REQ-029 Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - The count is log2(DEPTH)+1 bits.
  - full and empty are decoded from the count.
REQ-030 err SHALL clear only on reset.

Reset
REQ-031 Reset sets, asynchronously:
  - state IDLE;
  - ws=0, rdata=0, err=0;
  - pointers and count 0, so empty=1 and full=0.
REQ-032 Reset mid-read abandons the read; FIFO contents are discarded.

Structure
REQ-033 Package fsm_rd_pkg SHALL hold the state enum and the DATA_W and DEPTH defaults.
REQ-034 The FIFO (storage, pointers, count, full, empty) SHALL be sub-module rd_fifo.
  - It takes separate push and pop strobes.
  - Its head data output is combinational.

Verification
REQ-035 Push 0xA5; wait_cfg=0; rd high for 2 cycles, then ds:
  - ws stays 0; rdata=0xA5 from the cycle after rd rises;
  - empty=1 after ds.
REQ-036 Push 0x3C; wait_cfg=3; rd loops:
  - ws high for exactly 3 cycles, then 0; rdata=0x3C;
  - ds pops; err=0.
REQ-037 FIFO empty; rd=1, wait_cfg=0:
  - ws stays 1 for 10 cycles;
  - push 0x77; ws falls 2 cycles after the push; rdata=0x77.
REQ-038 Push 16 words 0..15; push 0xFF:
  - full=1 and err=1; 0xFF is dropped;
  - 16 reads return 0..15 in order, with wrap verified over a second fill.
REQ-039 Abort: rd drops in BUSY with ds=0:
  - state IDLE, ws=0; the head entry is retained;
  - the next read returns the same data.
REQ-040 Assert rst mid-BUSY with 3 entries:
  - ws=0 and empty=1 immediately, before the next clock edge;
  - a stray ds in IDLE afterwards sets err.
